// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gate enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        GATED     = 2'd2
    } cg_state_e;

    localparam int CG_CNT_W = 16;

    // Counter width able to hold n, with n clamped to at least 1.
    function automatic int cnt_w(input int n);
        return $clog2(((n < 1) ? 1 : n) + 1);
    endfunction

endpackage

// File: rtl/cg_down_cnt.sv
// Load/decrement down counter that saturates at zero and exposes only a zero flag.
// Load wins over decrement; zero flag is combinational from the count register.
module cg_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Drives the ICG enable from sleep status, firmware enable and wake sources.
// All outputs are flops; wake restores clk_en one cycle after it is sampled.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES   = 16,
    parameter int MIN_ON_CYCLES = 4,
    parameter int WAKE_W        = 4
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                cg_enable,
    input  logic                core_halted,
    input  logic                force_on,
    input  logic [WAKE_W-1:0]   wake_req,
    output logic                clk_en,
    output logic                cg_active,
    output logic                wake_ack,
    output logic [CG_CNT_W-1:0] gate_count
);

    localparam int IDLE_W = cnt_w(IDLE_CYCLES);
    localparam int MIN_W  = cnt_w(MIN_ON_CYCLES);
    localparam logic [IDLE_W-1:0]   IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [MIN_W-1:0]    MIN_LOAD  = MIN_W'(MIN_ON_CYCLES);
    localparam logic [CG_CNT_W-1:0] CNT_ONE   = CG_CNT_W'(1);

    cg_state_e             state;
    cg_state_e             nxt_state;
    logic                  gc;
    logic                  idle_load;
    logic                  idle_dec;
    logic                  idle_zero;
    logic                  min_load;
    logic                  min_dec;
    logic                  min_zero;
    logic                  gate_inc;
    logic [CG_CNT_W-1:0]   gate_cnt_q;

    assign gc = cg_enable & core_halted & ~force_on & ~(|wake_req);

    cg_down_cnt #(.W(IDLE_W)) u_idle_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (idle_load),
        .load_val (IDLE_LOAD),
        .dec      (idle_dec),
        .zero     (idle_zero)
    );

    cg_down_cnt #(.W(MIN_W)) u_min_on_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (min_load),
        .load_val (MIN_LOAD),
        .dec      (min_dec),
        .zero     (min_zero)
    );

    always_comb begin
        nxt_state = state;
        idle_load = 1'b0;
        idle_dec  = 1'b0;
        min_load  = 1'b0;
        min_dec   = 1'b0;
        gate_inc  = 1'b0;
        case (state)
            RUN: begin
                min_dec = 1'b1;
                if (gc && min_zero) begin
                    nxt_state = IDLE_WAIT;
                    idle_load = 1'b1;
                end
            end
            IDLE_WAIT: begin
                // A wake on the final idle cycle beats the gate decision.
                if (!gc) begin
                    nxt_state = RUN;
                end else if (idle_zero) begin
                    nxt_state = GATED;
                    gate_inc  = 1'b1;
                end else begin
                    idle_dec = 1'b1;
                end
            end
            GATED: begin
                if (!gc) begin
                    nxt_state = RUN;
                    min_load  = 1'b1;
                end
            end
            default: nxt_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= RUN;
            clk_en     <= 1'b1;
            cg_active  <= 1'b0;
            wake_ack   <= 1'b0;
            gate_cnt_q <= '0;
        end else begin
            state     <= nxt_state;
            clk_en    <= (nxt_state != GATED);
            cg_active <= (nxt_state == GATED);
            wake_ack  <= (state == GATED) && (nxt_state == RUN);
            if (gate_inc && (gate_cnt_q != '1)) begin
                gate_cnt_q <= gate_cnt_q + CNT_ONE;
            end
        end
    end

    assign gate_count = gate_cnt_q;

endmodule
